clk_period_monitor: RTL and testbench
=====================================

# clk_period_monitor

Measures a free-running clock using a faster reference clock and checks the measured period against an expected value and tolerance. The monitored clock is sampled as an asynchronous data input. The block serves as the checking end for the testbench clock generators and for on-chip clock-health checks. It reports each period and high time, flags out-of-tolerance periods with a sticky error, and flags a stalled clock.

## Interface
Parameters:
- CNT_W, 16, width of all cycle counters and measurement ports
- SYNC_STAGES, 2, flip-flop stages in the mon_clk_i synchronizer (≥2)

Ports:
- clk_i  in  1  reference clock; all logic on its rising edge
- rst_ni  in  1  synchronous active-low reset
- en_i  in  1  enable; low forces IDLE
- mon_clk_i  in  1  monitored clock, asynchronous to clk_i
- exp_period_i  in  CNT_W  expected period in clk_i cycles
- tol_i  in  CNT_W  allowed absolute deviation from exp_period_i
- timeout_i  in  CNT_W  stall threshold in clk_i cycles; 0 disables the stall check
- err_clr_i  in  1  clears err_o
- period_o  out  CNT_W  last measured period, in clk_i cycles
- high_o  out  CNT_W  last measured high time, in clk_i cycles
- valid_o  out  1  one-cycle pulse when period_o and high_o update
- err_o  out  1  sticky period-out-of-tolerance flag
- stuck_o  out  1  monitored clock stalled

## Operation
- mon_clk_i passes through SYNC_STAGES flops, giving `s`. A further register holds `s_d`.
- Rise detect: `rise = s & ~s_d`.
- FSM states:
  - IDLE: counters are held at 0. Go to ARM when en_i=1.
  - ARM: wait for the first rise. On rise go to MEASURE and load the counters. No valid_o is produced in ARM.
  - MEASURE: measure each interval between consecutive rises.
  - en_i=0 in any state → IDLE next cycle.
- Period counter `cnt`:
  - On rise: cnt ← 1.
  - Otherwise: cnt ← cnt+1, saturating at 2^CNT_W−1.
- High counter `hcnt`:
  - On rise: hcnt ← 1.
  - Otherwise: hcnt ← hcnt + s, saturating.
- On rise in MEASURE:
  - period_o ← cnt and high_o ← hcnt (the pre-update values).
  - valid_o=1 for one cycle.
- Error check uses the captured period P, compared at CNT_W+1 bits with no wrap:
  - If P > exp_period_i + tol_i → err_o ← 1.
  - If P + tol_i < exp_period_i → err_o ← 1.
- err_o is sticky and is cleared by err_clr_i. If err_clr_i and a new error occur in the same cycle, the set wins.
- Stall check, in ARM or MEASURE with timeout_i≠0:
  - stuck_o ← 1 when cnt ≥ timeout_i.
  - In ARM, cnt counts from ARM entry.
  - stuck_o ← 0 on the next rise or on leaving to IDLE.
  - stuck_o does not set err_o.
- Saturated count: a period that saturates is reported as 2^CNT_W−1 and error-checked normally.
- IDLE:
  - period_o and high_o hold their last values.
  - valid_o and stuck_o are 0.
  - err_o holds.
- Input constraint: the monitored high and low phases must each be ≥2 clk_i cycles. Behaviour is unspecified otherwise.

## Timing
- Reset values (rst_ni=0 at a clk_i edge):
  - FSM = IDLE.
  - cnt, hcnt, period_o, high_o = 0.
  - valid_o, err_o, stuck_o = 0.
  - Synchronizer flops and s_d = 0.
- Reset mid-measurement discards the interval in progress. The first valid_o comes after two new rises.
- Detection latency: a mon_clk_i rise is seen as `rise` SYNC_STAGES+1 clk_i edges later, ±1 cycle of synchronizer uncertainty.
- Update latency: valid_o, period_o, high_o and err_o update on the clk_i edge where rise=1, so they are visible the cycle after detect.
- Measurement values:
  - A steady monitored clock with a period of exactly N clk_i cycles gives period_o=N.
  - With H high cycles after synchronization, high_o=H.
- stuck_o asserts on the edge where cnt reaches timeout_i.
- en_i falling: takes effect at the next edge. An in-flight measurement is dropped without a valid_o.

## Test plan
- Steady clock, period 10 ref cycles, 50% duty; exp_period_i=10, tol_i=0 → first valid_o on the 2nd rise, then every 10 cycles with period_o=10, high_o=5, err_o=0.
- Period 13, 4 high; exp=10, tol=2 → period_o=13, high_o=4, err_o=1. Then err_clr_i pulse with no new error → err_o=0. Then period 8 → err_o stays 0.
- err_clr_i asserted in the same cycle as an out-of-tolerance valid_o → err_o=1.
- mon_clk_i held low after a rise, timeout_i=50 → stuck_o=1 when cnt=50. Resume clocking → stuck_o=0 on the next rise, with period_o equal to the full stalled interval.
- CNT_W=8, stall of 300 cycles, timeout_i=0 → period_o=255, err_o=1, stuck_o never asserted.
- rst_ni low for 1 cycle mid-interval → all outputs 0 next cycle, no valid_o until the 2nd rise after reset. Then en_i toggled low → IDLE, with period_o and high_o holding their values.

Source files
------------

// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//
// Measures a free-running monitored clock against a faster reference clock.
// Each full monitored period (rise to rise) and its high time are reported in
// reference cycles. Periods outside exp_period_i +/- tol_i set a sticky error.
// A clock that stops toggling for timeout_i reference cycles raises stuck_o.
//
// Ports
//   clk_i         reference clock, all logic on its rising edge
//   rst_ni        synchronous active-low reset
//   en_i          enable, low returns the monitor to IDLE
//   mon_clk_i     monitored clock, asynchronous to clk_i
//   exp_period_i  expected period in clk_i cycles
//   tol_i         allowed absolute deviation from exp_period_i
//   timeout_i     stall threshold in clk_i cycles, 0 disables the check
//   err_clr_i     clears err_o
//   period_o      last measured period
//   high_o        last measured high time
//   valid_o       one-cycle pulse when period_o/high_o update
//   err_o         sticky out-of-tolerance flag
//   stuck_o       monitored clock stalled
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | disabled; counters held at 0, results held
// ST_ARM     | waiting for the first rise, no result produced
// ST_MEASURE | every rise closes one interval and opens the next

module clk_period_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mon_clk_i,
    input  logic [CNT_W-1:0] exp_period_i,
    input  logic [CNT_W-1:0] tol_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             stuck_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d;
    logic                   rise;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             active;
    logic             capture;
    logic             out_of_tol;
    logic             stuck_d;

    logic [CNT_W:0]   p_ext, exp_ext, hi_lim, p_plus_tol;

    // Synchronizer for the asynchronous monitored clock, plus one more stage
    // for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARM;
                ST_ARM:     if (rise) state_d = ST_MEASURE;
                ST_MEASURE: state_d = ST_MEASURE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Error bounds are evaluated one bit wider so exp+tol and P+tol never wrap.
    assign p_ext      = {1'b0, cnt_q};
    assign exp_ext    = {1'b0, exp_period_i};
    assign hi_lim     = exp_ext + {1'b0, tol_i};
    assign p_plus_tol = p_ext + {1'b0, tol_i};

    always_comb begin
        active     = en_i && (state_q != ST_IDLE);
        capture    = active && (state_q == ST_MEASURE) && rise;
        out_of_tol = (p_ext > hi_lim) || (p_plus_tol < exp_ext);

        cnt_d  = '0;
        hcnt_d = '0;
        if (active) begin
            if (rise) begin
                cnt_d  = CNT_ONE;
                hcnt_d = CNT_ONE;
            end else begin
                cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                hcnt_d = (hcnt_q == CNT_MAX || !s) ? hcnt_q : hcnt_q + CNT_ONE;
            end
        end

        // Compare against the updated count so stuck_o rises on the same edge
        // the count reaches the threshold.
        stuck_d = 1'b0;
        if (active && timeout_i != '0 && !rise) begin
            stuck_d = (cnt_d >= timeout_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            stuck_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            valid_o <= capture;
            stuck_o <= stuck_d;
            if (capture) begin
                period_o <= cnt_q;
                high_o   <= hcnt_q;
            end
            // A new error in the same cycle as a clear request wins.
            if (capture && out_of_tol) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
module tb_clk_period_monitor;

    localparam int CNT_W = 8;
    localparam int MAXV  = 255;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             en_i = 1'b0;
    logic             mon_clk_i = 1'b0;
    logic [CNT_W-1:0] exp_period_i = 8'd10;
    logic [CNT_W-1:0] tol_i = 8'd0;
    logic [CNT_W-1:0] timeout_i = 8'd0;
    logic             err_clr_i = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             err_o;
    logic             stuck_o;

    clk_period_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .mon_clk_i    (mon_clk_i),
        .exp_period_i (exp_period_i),
        .tol_i        (tol_i),
        .timeout_i    (timeout_i),
        .err_clr_i    (err_clr_i),
        .period_o     (period_o),
        .high_o       (high_o),
        .valid_o      (valid_o),
        .err_o        (err_o),
        .stuck_o      (stuck_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    typedef struct {
        int p;
        int h;
        int e;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    last_p = 0;
    int    last_h = 0;
    bit    err_m = 1'b0;
    bit    en_m = 1'b0;
    bit    have_prev = 1'b0;
    int    prev_p = 0;
    int    prev_h = 0;
    bit    pushed_bad = 1'b0;

    always @(negedge clk_i) begin
        if (valid_o) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", 1, 0);
            end else begin
                mon_it = sb.pop_front();
                check_val("period", int'(period_o), mon_it.p);
                check_val("high", int'(high_o), mon_it.h);
                check_val("err", int'(err_o), mon_it.e);
                last_p = mon_it.p;
                last_h = mon_it.h;
            end
        end
    end

    // Expected result of the interval closed by the rise being driven now.
    task automatic push_expect();
        int p;
        bit bad;
        p   = (prev_p > MAXV) ? MAXV : prev_p;
        bad = (p > int'(exp_period_i) + int'(tol_i)) ||
              (p + int'(tol_i) < int'(exp_period_i));
        err_m      = err_m | bad;
        pushed_bad = bad;
        sb.push_back('{p, prev_h, int'(err_m)});
    endtask

    // One monitored period: rise at k=0, high for hi cycles, low for lo.
    // clr_at >= 0 pulses err_clr_i for one cycle starting at that index;
    // index 2 lands on the edge where the result of this rise is captured.
    task automatic drive_period(input int hi, input int lo, input int clr_at);
        for (int k = 0; k < hi + lo; k++) begin
            int c;
            int st;
            @(negedge clk_i);
            if (k >= 3) begin
                c  = (k - 2 > MAXV) ? MAXV : k - 2;
                st = (en_m && timeout_i != 0 && c >= int'(timeout_i)) ? 1 : 0;
                check_val("stuck", int'(stuck_o), st);
            end
            if (clr_at >= 0 && k == clr_at + 1) begin
                err_clr_i = 1'b0;
                check_val("err_after_clr", int'(err_o), int'(err_m));
            end
            if (k == 0) begin
                mon_clk_i  = 1'b1;
                pushed_bad = 1'b0;
                if (en_m) begin
                    if (have_prev) push_expect();
                    have_prev = 1'b1;
                    prev_p    = hi + lo;
                    prev_h    = hi;
                end
            end else if (k == hi) begin
                mon_clk_i = 1'b0;
            end
            if (k == clr_at) begin
                err_clr_i = 1'b1;
                err_m     = (k == 2) ? pushed_bad : 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_i);
        check_val("drain", sb.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_period"}, int'(period_o), 0);
        check_val({tag, "_high"}, int'(high_o), 0);
        check_val({tag, "_valid"}, int'(valid_o), 0);
        check_val({tag, "_err"}, int'(err_o), 0);
        check_val({tag, "_stuck"}, int'(stuck_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check_cleared("reset");
        rst_ni = 1'b1;

        // steady 10-cycle clock, 50% duty, exact match required
        exp_period_i = 8'd10;
        tol_i        = 8'd0;
        timeout_i    = 8'd0;
        en_i         = 1'b1;
        en_m         = 1'b1;
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 6; i++) drive_period(5, 5, -1);

        // too long with tol 2, then clear, then an in-range period of 8
        tol_i = 8'd2;
        for (int i = 0; i < 3; i++) drive_period(4, 9, -1);
        drive_period(4, 4, 5);
        for (int i = 0; i < 3; i++) drive_period(4, 4, -1);

        // clear requested on the same edge as a new error
        drive_period(4, 9, -1);
        drive_period(4, 4, 2);
        drive_period(4, 4, -1);

        // stall with timeout 50, then resume
        timeout_i = 8'd50;
        drive_period(5, 60, -1);
        drive_period(5, 5, -1);

        // saturating stall with the stall check disabled
        timeout_i = 8'd0;
        drive_period(5, 300, -1);
        drive_period(5, 5, -1);
        drive_period(5, 5, -1);

        // one-cycle reset in the middle of an interval
        drain();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_cleared("midreset");
        err_m     = 1'b0;
        have_prev = 1'b0;
        tol_i     = 8'd0;
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 4; i++) drive_period(5, 5, -1);

        // disable: no results, measurements hold
        drain();
        en_i      = 1'b0;
        en_m      = 1'b0;
        have_prev = 1'b0;
        @(negedge clk_i);
        check_val("idle_valid", int'(valid_o), 0);
        for (int i = 0; i < 3; i++) drive_period(5, 5, -1);
        check_val("idle_period_hold", int'(period_o), last_p);
        check_val("idle_high_hold", int'(high_o), last_h);
        check_val("idle_err_hold", int'(err_o), int'(err_m));
        check_val("idle_stuck", int'(stuck_o), 0);
        check_val("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
